// File: rtl/joypad_debounce.sv
// Purpose: synchronize and debounce eight active-low joypad pins into an active-high key vector plus edge pulses.
// Latency: a pin change held stable is visible on key/pressed/released STABLE_TICKS+3 clk edges after it is first sampled.
// Backpressure: none; pins are sampled every cycle and outputs are free-running, with no flow control.
module joypad_debounce #(
    parameter int unsigned STABLE_TICKS   = 50000,
    parameter bit          BLOCK_OPPOSING = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] joy_n,
    output logic [7:0] key,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic       any_press
);

    // Bit positions in the core's key order {down, up, left, right, start, select, b, a}.
    localparam int unsigned BIT_DOWN  = 7;
    localparam int unsigned BIT_UP    = 6;
    localparam int unsigned BIT_LEFT  = 5;
    localparam int unsigned BIT_RIGHT = 4;

    // Counter only needs to reach STABLE_TICKS-1, so it can never wrap.
    localparam int unsigned      CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       raw;
    logic [7:0]       deb;
    logic [7:0]       deb_nxt;
    logic [7:0]       key_nxt;
    logic [7:0]       press_nxt;
    logic [7:0]       release_nxt;
    logic [CNT_W-1:0] cnt     [8];
    logic [CNT_W-1:0] cnt_nxt [8];

    // Two-flop synchronizer; resets to all-ones so every button starts released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 8'hFF;
            s2 <= 8'hFF;
        end else begin
            s1 <= joy_n;
            s2 <= s1;
        end
    end

    // Pins are active-low; the debouncer works on the pressed sense.
    assign raw = ~s2;

    // Per-bit stability counter: any agreement clears it, a full run of disagreement flips deb.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = '0;
            if (raw[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_nxt[i] = raw[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounced state and counters; reset discards any count in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Optional masking of physically impossible direction pairs before they reach the core.
    always_comb begin
        key_nxt = deb;
        if (BLOCK_OPPOSING) begin
            if (deb[BIT_DOWN] && deb[BIT_UP]) begin
                key_nxt[BIT_DOWN] = 1'b0;
                key_nxt[BIT_UP]   = 1'b0;
            end
            if (deb[BIT_LEFT] && deb[BIT_RIGHT]) begin
                key_nxt[BIT_LEFT]  = 1'b0;
                key_nxt[BIT_RIGHT] = 1'b0;
            end
        end
    end

    // Edges are taken between the value about to be registered and the current key, which plays the
    // role of the delayed copy; registering the result lines pulses up with the first cycle key changes.
    always_comb begin
        press_nxt   = key_nxt & ~key;
        release_nxt = ~key_nxt & key;
    end

    // Registered key and edge pulses; reset forces everything low and produces no pulse of its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            key       <= 8'h00;
            pressed   <= 8'h00;
            released  <= 8'h00;
            any_press <= 1'b0;
        end else begin
            key       <= key_nxt;
            pressed   <= press_nxt;
            released  <= release_nxt;
            any_press <= |press_nxt;
        end
    end

endmodule
